// File: rtl/coin_sensor_tx_if.sv
// Coin-sensor link bundle: frame request and word selection towards the transmitter,
// serial data and status back.
//   start      frame request
//   raw_mode   1 = send raw_value, 0 = send coin-table word
//   coin_sel   0 penny, 1 nickle, 2 dime, 3 quarter
//   raw_value  word sent in raw mode
//   serialOut  serial data, LSB first
//   write      high during the 10 data cycles
//   busy       frame (data + gap) in progress
//   done       one-cycle pulse on the last gap cycle
interface coin_sensor_tx_if;
    logic       start;
    logic       raw_mode;
    logic [1:0] coin_sel;
    logic [9:0] raw_value;
    logic       serialOut;
    logic       write;
    logic       busy;
    logic       done;

    modport master (
        output start, raw_mode, coin_sel, raw_value,
        input  serialOut, write, busy, done
    );

    modport slave (
        input  start, raw_mode, coin_sel, raw_value,
        output serialOut, write, busy, done
    );
endinterface

// File: rtl/coin_sensor_tx.sv
// Serial transmitter for the coin-sensor link. On an accepted start it captures a 10-bit
// word (coin-table value or raw value), shifts it out LSB first with write high, then holds
// write low for GAP_CYCLES cycles so the receiver can classify the coin.
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    coin_sensor_tx_if slave side (start/raw_mode/coin_sel/raw_value in,
//          serialOut/write/busy/done out, all outputs registered)
module coin_sensor_tx #(
    parameter int unsigned GAP_CYCLES = 2  // legal range 1..15
) (
    input logic             clk,
    input logic             reset,
    coin_sensor_tx_if.slave bus
);

    localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] BitLast = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] shreg_q, shreg_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ser_q, ser_d;
    logic       write_q, write_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [9:0] word;
    logic [3:0] cnt_inc;

    assign cnt_inc = cnt_q + 4'd1;

    // Mid-band word of each receiver window.
    always_comb begin
        word = 10'h000;
        if (bus.raw_mode) begin
            word = bus.raw_value;
        end else begin
            unique case (bus.coin_sel)
                2'd0:    word = 10'h2EE;
                2'd1:    word = 10'h343;
                2'd2:    word = 10'h2C1;
                default: word = 10'h3BB;
            endcase
        end
    end

    // Outputs are computed for the cycle after the edge, so every output is a flop.
    // In SHIFT, cnt_q is the index of the bit currently on serialOut; in GAP it is the
    // index of the current gap cycle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ser_d   = 1'b0;
        write_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    // Bit 0 goes straight to the output flop; the rest waits in shreg.
                    ser_d   = word[0];
                    shreg_d = {1'b0, word[9:1]};
                    write_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = StShift;
                end
            end
            StShift: begin
                busy_d = 1'b1;
                if (cnt_q == BitLast) begin
                    cnt_d   = 4'd0;
                    done_d  = (GapLast == 4'd0);
                    state_d = StGap;
                end else begin
                    ser_d   = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[9:1]};
                    write_d = 1'b1;
                    cnt_d   = cnt_inc;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = StIdle;
                end else begin
                    busy_d = 1'b1;
                    done_d = (cnt_inc == GapLast);
                    cnt_d  = cnt_inc;
                end
            end
            default: begin
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            shreg_q <= 10'h000;
            cnt_q   <= 4'd0;
            ser_q   <= 1'b0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            write_q <= write_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.serialOut = ser_q;
    assign bus.write     = write_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
